// File: rtl/code_compare_seq.sv
// Keypad code datapath for the digital lock: entry buffer, digit-serial compare against PC/UC/candidate,
// and user-code reprogramming. Define LOCKOUT_EN to add the failed-attempt lockout timer.
module code_compare_seq #(
    parameter int          MAX_LEN        = 8,
    parameter int          MIN_LEN        = 4,
    parameter int          PC_LEN         = 6,
    parameter logic [31:0] DEFAULT_UC     = 32'h1234,
    parameter int          DEFAULT_UC_LEN = 4,
    parameter logic [23:0] DEFAULT_PC     = 24'h654321,
    parameter int          LOCKOUT_CYC    = 1000
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] button,
    input  logic       clear,
    input  logic       compare_start,
    input  logic [1:0] compareType,
    input  logic       store,
    output logic       data_ready,
    output logic       correct_input,
    output logic       validLength,
    output logic       validLengthPC,
    output logic       busy,
    output logic       lockout
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef logic [MAX_LEN-1:0][3:0] code_t;
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_CMP, S_DONE} state_t;

    // The default user code literal reads in key-entry order (first key in the top nibble).
    function automatic code_t uc_init();
        code_t c = '0;
        for (int i = 0; i < DEFAULT_UC_LEN; i++) c[i] = DEFAULT_UC[4*(DEFAULT_UC_LEN-1-i) +: 4];
        return c;
    endfunction

    function automatic code_t pc_init();
        code_t c = '0;
        for (int i = 0; i < PC_LEN; i++) c[i] = DEFAULT_PC[4*i +: 4];
        return c;
    endfunction

    localparam code_t UC_INIT = uc_init();
    localparam code_t PC_CODE = pc_init();

    state_t          state_q;
    code_t           buf_q, uc_q, cand_q;
    logic [LW-1:0]   len_q, uc_len_q, cand_len_q;
    logic            overflow_q;
    logic [1:0]      type_q;
    logic [IW-1:0]   idx_q;
    logic            fin_q, res_q, commit_ok_q;
    logic            data_ready_q, correct_q;

    logic [LW-1:0]   tgt_len;
    logic [3:0]      tgt_digit;
    logic            len_ok, mismatch, last, fin_now, fin_raw, fin_res, counted, lock_w;

    always_comb begin
        tgt_len   = cand_len_q;
        tgt_digit = cand_q[idx_q];
        case (type_q)
            2'b00:   begin tgt_len = LW'(PC_LEN); tgt_digit = PC_CODE[idx_q]; end
            2'b01:   begin tgt_len = uc_len_q;    tgt_digit = uc_q[idx_q];    end
            default: ;
        endcase
    end

    assign validLength   = (len_q >= LW'(MIN_LEN)) && (len_q <= LW'(MAX_LEN)) && !overflow_q;
    assign validLengthPC = (len_q == LW'(PC_LEN)) && !overflow_q;
    assign len_ok        = (len_q == tgt_len) && (len_q != '0) && !overflow_q;
    assign mismatch      = buf_q[idx_q] != tgt_digit;
    assign last          = (LW'(idx_q) + LW'(1)) == tgt_len;
    // Length-fail and capture results are parked in res_q and retired from CMP, giving a fixed 2-cycle path.
    assign fin_now       = fin_q | mismatch | last;
    assign fin_raw       = fin_q ? res_q : !mismatch;
    assign fin_res       = fin_raw & ~lock_w;
    assign counted       = !type_q[1];

    assign data_ready    = data_ready_q;
    assign correct_input = correct_q;
    assign busy          = (state_q == S_LEN) || (state_q == S_CMP);

`ifdef LOCKOUT_EN
    localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    logic [1:0]    fail_cnt_q;
    logic          lock_q;
    logic [TW-1:0] lock_tmr_q;
    assign lock_w  = lock_q;
    assign lockout = lock_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^LOCKOUT_CYC;
    assign lock_w  = 1'b0;
    assign lockout = 1'b0;
`endif

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            uc_q         <= UC_INIT;
            cand_q       <= '0;
            len_q        <= '0;
            uc_len_q     <= LW'(DEFAULT_UC_LEN);
            cand_len_q   <= '0;
            overflow_q   <= 1'b0;
            type_q       <= 2'b00;
            idx_q        <= '0;
            fin_q        <= 1'b0;
            res_q        <= 1'b0;
            commit_ok_q  <= 1'b0;
            data_ready_q <= 1'b0;
            correct_q    <= 1'b0;
`ifdef LOCKOUT_EN
            fail_cnt_q   <= 2'd0;
            lock_q       <= 1'b0;
            lock_tmr_q   <= '0;
`endif
        end else begin
`ifdef LOCKOUT_EN
            // The timer runs independently of clear so a lockout cannot be cut short.
            if (lock_q) begin
                if (lock_tmr_q == TW'(LOCKOUT_CYC - 1)) begin
                    lock_q     <= 1'b0;
                    fail_cnt_q <= 2'd0;
                    lock_tmr_q <= '0;
                end else begin
                    lock_tmr_q <= lock_tmr_q + TW'(1);
                end
            end
`endif
            if (clear) begin
                state_q      <= S_IDLE;
                len_q        <= '0;
                overflow_q   <= 1'b0;
                commit_ok_q  <= 1'b0;
                data_ready_q <= 1'b0;
                correct_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (compare_start) begin
                            type_q      <= compareType;
                            commit_ok_q <= 1'b0;
                            state_q     <= S_LEN;
                        end else if (digit_valid && button < 4'd7) begin
                            if (len_q == LW'(MAX_LEN)) begin
                                overflow_q <= 1'b1;
                            end else begin
                                buf_q[len_q[IW-1:0]] <= button;
                                len_q                <= len_q + LW'(1);
                            end
                        end
                    end
                    S_LEN: begin
                        idx_q   <= '0;
                        state_q <= S_CMP;
                        if (type_q == 2'b11) begin
                            cand_q     <= buf_q;
                            cand_len_q <= len_q;
                            res_q      <= validLength;
                            fin_q      <= 1'b1;
                        end else begin
                            res_q <= 1'b0;
                            fin_q <= !len_ok;
                        end
                    end
                    S_CMP: begin
                        if (fin_now) begin
                            state_q      <= S_DONE;
                            data_ready_q <= 1'b1;
                            correct_q    <= fin_res;
                            commit_ok_q  <= (type_q == 2'b10) && fin_res;
`ifdef LOCKOUT_EN
                            if (counted && !lock_q) begin
                                if (fin_raw) begin
                                    fail_cnt_q <= 2'd0;
                                end else if (fail_cnt_q == 2'd2) begin
                                    lock_q     <= 1'b1;
                                    lock_tmr_q <= '0;
                                end else begin
                                    fail_cnt_q <= fail_cnt_q + 2'd1;
                                end
                            end
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                    S_DONE: begin
                        if (compare_start) begin
                            type_q       <= compareType;
                            commit_ok_q  <= 1'b0;
                            data_ready_q <= 1'b0;
                            correct_q    <= 1'b0;
                            state_q      <= S_LEN;
                        end else if (store && commit_ok_q) begin
                            uc_q        <= cand_q;
                            uc_len_q    <= cand_len_q;
                            commit_ok_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifndef LOCKOUT_EN
    logic unused_cnt;
    assign unused_cnt = counted;
`endif

endmodule
